// File: rtl/difftest_pkg.sv
// difftest_pkg: shared commit entry, ebreak encoding and controller states
package difftest_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] npc;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } commit_entry_t;
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: DEPTH-entry queue of retired instructions awaiting the difftest host
module commit_fifo
   import difftest_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  commit_entry_t                  din,
   output commit_entry_t                  dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   commit_entry_t mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop & ~empty;
   // a full queue still takes a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rp];
   always_ff @(posedge clock)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge clock) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= do_push ? wp + 1'b1 : wp;
         rp    <= do_pop ? rp + 1'b1 : rp;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/difftest_commit_ctrl.sv
// difftest_commit_ctrl: queues WB retirements and strobes them to the difftest host,
// tracking ebreak halt, idle timeout and queue overflow.
module difftest_commit_ctrl
   import difftest_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wb_valid,
   input  logic [31:0]                wb_pc,
   input  logic [31:0]                wb_inst,
   input  logic [31:0]                wb_npc,
   input  logic                       wb_wen,
   input  logic [4:0]                 wb_waddr,
   input  logic [31:0]                wb_wdata,
   input  logic                       dpi_ready,
   output logic                       commit,
   output logic [31:0]                c_pc,
   output logic [31:0]                c_inst,
   output logic [31:0]                c_npc,
   output logic [31:0]                c_wdata,
   output logic                       c_wen,
   output logic [4:0]                 c_waddr,
   output logic                       halt,
   output logic                       timeout,
   output logic                       overflow,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int IW = $clog2(TIMEOUT);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
   state_t state, state_nx;
   commit_entry_t wb_entry, head, c_q;
   logic full, empty, push, pop;
   logic [IW-1:0] idle, idle_nx;
   assign wb_entry = '{pc: wb_pc, inst: wb_inst, npc: wb_npc, wen: wb_wen, waddr: wb_waddr, wdata: wb_wdata};
   assign pop  = ~empty & dpi_ready & (state != HALTED);
   assign push = wb_valid & (state == RUN) & (~full | pop);
   commit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (wb_entry),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   // halt waits for the ebreak strobe itself so the host sees it before stopping
   always_comb begin
      state_nx = (state == RUN && push && wb_inst == EBREAK_INST) ? DRAIN :
                 (state == DRAIN && commit && c_q.inst == EBREAK_INST) ? HALTED : state;
      idle_nx  = push ? '0 : (idle == IDLE_MAX ? idle : idle + 1'b1);
   end
   always_ff @(posedge clock) begin
      if (reset) state <= RUN;
      else       state <= state_nx;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         commit   <= 1'b0;
         c_q      <= '0;
         overflow <= 1'b0;
         timeout  <= 1'b0;
         idle     <= '0;
      end else begin
         commit   <= pop;
         c_q      <= pop ? head : c_q;
         overflow <= overflow | (wb_valid & (state == RUN) & full & ~pop);
         idle     <= (state == RUN) ? idle_nx : idle;
         timeout  <= timeout | ((state == RUN) & (idle_nx == IDLE_MAX));
      end
   end
   assign halt    = state == HALTED;
   assign c_pc    = c_q.pc;
   assign c_inst  = c_q.inst;
   assign c_npc   = c_q.npc;
   assign c_wdata = c_q.wdata;
   assign c_wen   = c_q.wen;
   assign c_waddr = c_q.waddr;
endmodule

// File: tb/tb_difftest_commit_ctrl.sv
// tb_difftest_commit_ctrl: directed vectors against a queue-level model plus literal expectations
module tb_difftest_commit_ctrl;
   import difftest_pkg::*;
   localparam int DEPTH = 4;
   localparam int TO    = 16;
   logic clock = 1'b0, reset = 1'b1;
   logic wb_valid = 1'b0, wb_wen = 1'b0, dpi_ready = 1'b0;
   logic [31:0] wb_pc = '0, wb_inst = '0, wb_npc = '0, wb_wdata = '0;
   logic [4:0] wb_waddr = '0;
   logic commit, c_wen, halt, timeout, overflow;
   logic [31:0] c_pc, c_inst, c_npc, c_wdata;
   logic [4:0] c_waddr;
   logic [2:0] count;
   int checks = 0, errors = 0;
   commit_entry_t q[$];
   commit_entry_t m_c;
   bit m_commit, m_to, m_ov;
   int m_state, m_idle;

   always #5 clock = ~clock;

   difftest_commit_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
      .wb_npc(wb_npc), .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .dpi_ready(dpi_ready), .commit(commit), .c_pc(c_pc), .c_inst(c_inst), .c_npc(c_npc),
      .c_wdata(c_wdata), .c_wen(c_wen), .c_waddr(c_waddr), .halt(halt), .timeout(timeout),
      .overflow(overflow), .count(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int i);
      return {12'(i), 8'h00, 5'(i), 7'h13};
   endfunction

   // state: 0 run, 1 drain, 2 halted; the queue holds entries not yet committed
   task automatic model_step();
      int sz, nst;
      bit popd, acc;
      if (reset) begin
         q.delete();
         m_commit = 0; m_c = '0; m_state = 0; m_idle = 0; m_to = 0; m_ov = 0;
         return;
      end
      sz   = q.size();
      popd = sz > 0 && dpi_ready && m_state != 2;
      acc  = wb_valid && m_state == 0 && (sz < DEPTH || popd);
      nst  = (m_state == 1 && m_commit && m_c.inst == EBREAK_INST) ? 2 : m_state;
      if (wb_valid && m_state == 0 && !acc) m_ov = 1;
      m_commit = popd;
      if (popd) m_c = q.pop_front();
      if (acc) begin
         q.push_back('{pc: wb_pc, inst: wb_inst, npc: wb_npc, wen: wb_wen, waddr: wb_waddr, wdata: wb_wdata});
         if (wb_inst == EBREAK_INST) nst = 1;
      end
      if (m_state == 0) begin
         m_idle = acc ? 0 : (m_idle < TO - 1 ? m_idle + 1 : m_idle);
         if (m_idle == TO - 1) m_to = 1;
      end
      m_state = nst;
   endtask

   task automatic compare_model();
      chk("m_commit", 32'(commit), 32'(m_commit));
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_halt", 32'(halt), 32'(m_state == 2));
      chk("m_timeout", 32'(timeout), 32'(m_to));
      chk("m_overflow", 32'(overflow), 32'(m_ov));
      chk("m_c_pc", c_pc, m_c.pc);
      chk("m_c_inst", c_inst, m_c.inst);
      chk("m_c_npc", c_npc, m_c.npc);
      chk("m_c_wdata", c_wdata, m_c.wdata);
      chk("m_c_wen", 32'(c_wen), 32'(m_c.wen));
      chk("m_c_waddr", 32'(c_waddr), 32'(m_c.waddr));
   endtask

   task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit rdy);
      wb_valid = v; wb_pc = pc; wb_inst = inst; wb_npc = pc + 32'd4;
      wb_wen = inst[4]; wb_waddr = inst[11:7]; wb_wdata = {20'h0, inst[31:20]};
      dpi_ready = rdy;
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_model();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_count", 32'(count), 0);
      chk("rst_commit", 32'(commit), 0);
      chk("rst_flags", {29'h0, halt, timeout, overflow}, 0);
      chk("rst_c_pc", c_pc, 0);
      // two-cycle latency to the commit strobe
      cyc(1, 32'h8000_0000, 32'h0050_0093, 1);
      chk("lat_c1_commit", 32'(commit), 0);
      chk("lat_c1_count", 32'(count), 1);
      cyc(0, 0, 0, 1);
      chk("lat_commit", 32'(commit), 1);
      chk("lat_c_pc", c_pc, 32'h8000_0000);
      chk("lat_c_inst", c_inst, 32'h0050_0093);
      chk("lat_c_npc", c_npc, 32'h8000_0004);
      chk("lat_c_wen", 32'(c_wen), 1);
      chk("lat_c_waddr", 32'(c_waddr), 1);
      chk("lat_c_wdata", c_wdata, 5);
      chk("lat_count", 32'(count), 0);
      cyc(0, 0, 0, 1);
      chk("lat_strobe_len", 32'(commit), 0);
      chk("lat_hold_pc", c_pc, 32'h8000_0000);
      // fill, overflow, then drain in order
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(4 * i), mk(i + 1), 0);
      chk("full_count", 32'(count), 4);
      chk("full_commit", 32'(commit), 0);
      chk("full_ovf", 32'(overflow), 0);
      cyc(1, 32'h110, mk(9), 0);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_count", 32'(count), 4);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1);
         chk("drain_commit", 32'(commit), 1);
         chk("drain_pc", c_pc, 32'h100 + 32'(4 * i));
      end
      cyc(0, 0, 0, 1);
      chk("drain_done_commit", 32'(commit), 0);
      chk("drain_done_count", 32'(count), 0);
      // push and pop together while full, across pointer wrap
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 32'(4 * i), mk(i + 32), 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 32'h210 + 32'(4 * i), mk(i + 48), 1);
         chk("wrap_count", 32'(count), 4);
         chk("wrap_ovf", 32'(overflow), 0);
         chk("wrap_commit", 32'(commit), 1);
         chk("wrap_pc", c_pc, 32'h200 + 32'(4 * i));
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1);
         chk("wrap_tail_commit", 32'(commit), 1);
         chk("wrap_tail_pc", c_pc, 32'h210 + 32'(4 * i));
      end
      // ebreak drains the queue then halts
      do_reset();
      cyc(1, 32'h300, mk(1), 0);
      cyc(1, 32'h304, mk(2), 0);
      cyc(1, 32'h308, EBREAK_INST, 0);
      cyc(1, 32'h30c, mk(3), 0);
      chk("ebk_ignored_count", 32'(count), 3);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1);
         chk("ebk_commit", 32'(commit), 1);
         chk("ebk_pc", c_pc, 32'h300 + 32'(4 * i));
         chk("ebk_halt_early", 32'(halt), 0);
      end
      chk("ebk_inst", c_inst, 32'h0010_0073);
      cyc(1, 32'h310, mk(4), 1);
      chk("halt_set", 32'(halt), 1);
      chk("halt_commit", 32'(commit), 0);
      chk("halt_count", 32'(count), 0);
      repeat (3) cyc(1, 32'h314, mk(5), 1);
      chk("halt_sticky", 32'(halt), 1);
      chk("halt_no_commit", 32'(commit), 0);
      chk("halt_no_push", 32'(count), 0);
      // idle timeout, and a push restarting it
      do_reset();
      repeat (14) cyc(0, 0, 0, 0);
      chk("to_early", 32'(timeout), 0);
      cyc(0, 0, 0, 0);
      chk("to_set", 32'(timeout), 1);
      do_reset();
      repeat (10) cyc(0, 0, 0, 0);
      cyc(1, 32'h400, mk(1), 0);
      repeat (14) cyc(0, 0, 0, 0);
      chk("to_restart_early", 32'(timeout), 0);
      cyc(0, 0, 0, 0);
      chk("to_restart_set", 32'(timeout), 1);
      // reset in the middle of traffic wins over push and pop
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 32'h500 + 32'(4 * i), mk(i + 64), 0);
      cyc(0, 0, 0, 1);
      chk("mid_count", 32'(count), 3);
      chk("mid_ovf", 32'(overflow), 1);
      reset = 1'b1;
      cyc(1, 32'h600, mk(7), 1);
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_commit", 32'(commit), 0);
      chk("mid_rst_flags", {29'h0, halt, timeout, overflow}, 0);
      chk("mid_rst_c_pc", c_pc, 0);
      reset = 1'b0;
      cyc(1, 32'h604, mk(8), 1);
      cyc(0, 0, 0, 1);
      chk("mid_run_commit", 32'(commit), 1);
      chk("mid_run_pc", c_pc, 32'h604);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/difftest_commit_ctrl.md
DIFFTEST_COMMIT_CTRL -- requirements
Module: difftest_commit_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, commit queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 4096, idle cycles without a WB commit before the timeout flag is raised.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wb_valid  input  1  one instruction retires in WB this cycle.
REQ-006 SHALL have ports wb_pc / wb_inst / wb_npc  input  32 each  retiring pc, instruction, next pc.
REQ-007 SHALL have ports wb_wen  input  1, wb_waddr  input  5, wb_wdata  input  32  regfile write of the retiring instruction.
REQ-008 SHALL have port dpi_ready  input  1  difftest host can accept a commit this cycle.
REQ-009 SHALL have port commit  output  1  one-cycle strobe to the DPI commit hook.
REQ-010 SHALL have ports c_pc / c_inst / c_npc / c_wdata  output  32 each, c_wen  output  1, c_waddr  output  5  fields of the committed entry.
REQ-011 SHALL have ports halt, timeout, overflow  output  1 each  sticky status flags.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  current queue occupancy.

Function
REQ-013 SHALL push {pc,inst,npc,wen,waddr,wdata} into a FIFO on a cycle with wb_valid=1 and state RUN; pushes in DRAIN or HALTED SHALL be ignored.
REQ-014 SHALL pop the head when count>0, dpi_ready=1 and state is not HALTED.
REQ-015 SHALL register outputs: a pop in cycle t drives commit=1 and the head fields in cycle t+1; commit=0 otherwise, fields hold the last committed values.
REQ-016 SHALL give minimum latency of 2 cycles from wb_valid to commit (empty queue, dpi_ready=1), so the regfile write is visible before the host compares.
REQ-017 SHALL, when full, accept a push only if a pop occurs in the same cycle; otherwise drop the entry and set overflow (sticky).
REQ-018 SHALL, on simultaneous push and pop, leave count unchanged; pointers wrap modulo DEPTH.
REQ-019 SHALL implement states RUN, DRAIN, HALTED; RUN->DRAIN when the pushed inst is 0x00100073 (ebreak); DRAIN->HALTED in the cycle the ebreak entry's commit strobe is driven.
REQ-020 SHALL assert halt (sticky) from the first cycle in HALTED; HALTED is left only by reset.
REQ-021 SHALL keep an idle counter in RUN: cleared on accepted push, incremented otherwise, saturating; timeout set (sticky) when it reaches TIMEOUT-1; counter frozen in DRAIN/HALTED.
REQ-022 SHALL hold all entries while dpi_ready=0, with no commit strobe.

Reset
REQ-023 SHALL, on reset, empty the FIFO, enter RUN, clear the idle counter, and drive commit=0, all c_* =0, halt=0, timeout=0, overflow=0, count=0.
REQ-024 SHALL give reset priority over every push/pop in the same cycle; queued entries are discarded mid-operation.

Structure
REQ-025 SHALL place the commit entry struct, EBREAK_INST constant and state enum in shared package difftest_pkg.
REQ-026 SHALL implement the queue as sub-module commit_fifo (DEPTH-parameterised, push/pop/full/empty/count); the FSM, timeout and output registers live in the top.
REQ-027 SHALL be synthesisable apart from its consumer; DPI calls remain in the existing DPI blackbox, driven from commit and c_*.

Verification
REQ-028 SHALL test: reset; wb_valid pulse pc=0x80000000, inst=0x00500093, wen=1, waddr=1, wdata=5, dpi_ready=1 -> commit=1 exactly 2 cycles later with those fields, count back to 0.
REQ-029 SHALL test: dpi_ready=0, 4 pushes (DEPTH=4) -> count=4, no commit; 5th push -> overflow=1, count=4; dpi_ready=1 -> 4 strobes in order on consecutive cycles.
REQ-030 SHALL test: full queue, push and pop in the same cycle -> count stays 4, overflow stays 0, FIFO order preserved across wrap.
REQ-031 SHALL test: push ebreak 0x00100073 behind 2 entries -> later wb_valid ignored, 3 commits, halt=1 in the ebreak strobe cycle+1, no further commits.
REQ-032 SHALL test: TIMEOUT=16, no wb_valid for 15 cycles after reset -> timeout=1 on the 16th cycle; a push earlier restarts the count.
REQ-033 SHALL test: reset asserted with count=3 -> next cycle count=0, commit=0, state RUN, all flags 0.
